// File: rtl/core_msg_arbiter.sv
// -----------------------------------------------------------------------------
// core_msg_arbiter
//
// Merges the fire-and-forget status messages of CORE_COUNT core wrappers onto
// a single ready/valid stream, tagging each message with its source core.
// Every channel has a small FIFO so that simultaneous messages are kept.
// The cores cannot be stalled, so a message arriving at a full FIFO is
// discarded and counted in a per-core saturating drop counter.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (release synchronised inside)
//   s_msg_data   per-core message, core i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_msg_valid  per-core one-cycle message strobe (no ready)
//   m_msg_data   merged message
//   m_msg_id     index of the core that sent m_msg_data
//   m_msg_valid  output valid
//   m_msg_ready  output ready
//   drop_count   per-core saturating drop counters, DROP_CNT_WIDTH each
//   clear_drops  synchronous clear of every drop counter
//
// Handshake: a transfer happens on a rising edge where m_msg_valid and
// m_msg_ready are both 1. While m_msg_valid=1 and m_msg_ready=0, m_msg_data
// and m_msg_id hold stable and m_msg_valid stays 1 until the transfer.
// -----------------------------------------------------------------------------
module core_msg_arbiter #(
  parameter int CORE_COUNT     = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int FIFO_DEPTH     = 4,
  parameter int CORE_ID_WIDTH  = $clog2(CORE_COUNT),
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [CORE_COUNT*DATA_WIDTH-1:0]   s_msg_data,
  input  logic [CORE_COUNT-1:0]              s_msg_valid,
  output logic [DATA_WIDTH-1:0]              m_msg_data,
  output logic [CORE_ID_WIDTH-1:0]           m_msg_id,
  output logic                               m_msg_valid,
  input  logic                               m_msg_ready,
  output logic [CORE_COUNT*DROP_CNT_WIDTH-1:0] drop_count,
  input  logic                               clear_drops
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;  // extra wrap bit separates full from empty
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;
  localparam logic [CORE_ID_WIDTH-1:0]  LAST_CORE = CORE_ID_WIDTH'(CORE_COUNT - 1);

  // ---------------------------------------------------------------------------
  // Reset release synchroniser: the datapath stays idle until the second flop
  // has seen rst_n high, so the first push is taken on the third edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  // ---------------------------------------------------------------------------
  // Per-channel FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]     mem      [CORE_COUNT][FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr   [CORE_COUNT];
  logic [PW-1:0]             rd_ptr   [CORE_COUNT];
  logic [DROP_CNT_WIDTH-1:0] drop_cnt [CORE_COUNT];

  logic [CORE_COUNT-1:0] fifo_empty;
  logic [CORE_COUNT-1:0] fifo_full;
  logic [CORE_COUNT-1:0] push;
  logic [CORE_COUNT-1:0] pop;
  logic [CORE_COUNT-1:0] drop;

  logic [CORE_ID_WIDTH-1:0] last_grant;
  logic [CORE_ID_WIDTH-1:0] grant;
  logic                     grant_found;
  logic                     load;

  // Output register may take a new entry when empty or when it transfers now.
  assign load = run && (!m_msg_valid || m_msg_ready);

  always_comb begin
    for (int i = 0; i < CORE_COUNT; i++) begin
      fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
      fifo_full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                      (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
    end
  end

  // Round-robin pick: first non-empty channel at or after last_grant+1.
  always_comb begin
    int                       idx;
    logic [CORE_ID_WIDTH-1:0] cand;
    grant       = '0;
    grant_found = 1'b0;
    idx         = 0;
    cand        = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      idx  = (int'(last_grant) + 1 + k) % CORE_COUNT;
      cand = CORE_ID_WIDTH'(idx);
      if (!grant_found && !fifo_empty[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  // A full FIFO being popped this cycle still has room for a push.
  always_comb begin
    for (int i = 0; i < CORE_COUNT; i++) begin
      pop[i]  = load && grant_found && (grant == CORE_ID_WIDTH'(i));
      push[i] = run && s_msg_valid[i] && (!fifo_full[i] || pop[i]);
      drop[i] = run && s_msg_valid[i] && fifo_full[i] && !pop[i];
    end
  end

  // Storage is not reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= s_msg_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CORE_COUNT; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CORE_COUNT; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counters: saturate at all-ones; a clear coinciding with a drop
  // leaves the count at 1 so that drop is not lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CORE_COUNT; i++) drop_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CORE_COUNT; i++) begin
        if (clear_drops) begin
          drop_cnt[i] <= drop[i] ? DROP_CNT_WIDTH'(1) : '0;
        end else if (drop[i] && drop_cnt[i] != DROP_MAX) begin
          drop_cnt[i] <= drop_cnt[i] + DROP_CNT_WIDTH'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < CORE_COUNT; g++) begin : g_drop_out
    assign drop_count[g*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = drop_cnt[g];
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_msg_valid <= 1'b0;
      m_msg_data  <= '0;
      m_msg_id    <= '0;
      last_grant  <= LAST_CORE;
    end else if (load) begin
      m_msg_valid <= grant_found;
      if (grant_found) begin
        m_msg_data <= mem[grant][rd_ptr[grant][AW-1:0]];
        m_msg_id   <= grant;
        last_grant <= grant;
      end
    end
  end

endmodule

// File: tb/tb_core_msg_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for core_msg_arbiter (4 cores, 64-bit data, depth 4,
// 16-bit drop counters). Inputs are driven and outputs sampled 1 ns after
// each rising edge.
// -----------------------------------------------------------------------------
module tb_core_msg_arbiter;

  localparam int NC = 4;
  localparam int DW = 64;
  localparam int IW = 2;
  localparam int CW = 16;

  logic               clk;
  logic               rst_n;
  logic [NC*DW-1:0]   s_msg_data;
  logic [NC-1:0]      s_msg_valid;
  logic [DW-1:0]      m_msg_data;
  logic [IW-1:0]      m_msg_id;
  logic               m_msg_valid;
  logic               m_msg_ready;
  logic [NC*CW-1:0]   drop_count;
  logic               clear_drops;

  int tests_run;
  int tests_failed;

  core_msg_arbiter #(
    .CORE_COUNT(NC), .DATA_WIDTH(DW), .FIFO_DEPTH(4),
    .CORE_ID_WIDTH(IW), .DROP_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_msg_data(s_msg_data), .s_msg_valid(s_msg_valid),
    .m_msg_data(m_msg_data), .m_msg_id(m_msg_id),
    .m_msg_valid(m_msg_valid), .m_msg_ready(m_msg_ready),
    .drop_count(drop_count), .clear_drops(clear_drops)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, and wait out the synchroniser: the next edge accepts.
  task automatic do_reset();
    rst_n       = 1'b0;
    s_msg_valid = '0;
    s_msg_data  = '0;
    clear_drops = 1'b0;
    m_msg_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic send(input int core, input logic [DW-1:0] d);
    s_msg_data = '0;
    s_msg_data[core*DW +: DW] = d;
    s_msg_valid = '0;
    s_msg_valid[core] = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    s_msg_valid = '0;
    s_msg_data = '0;
    clear_drops = 1'b0;
    m_msg_ready = 1'b1;
    #2;
    tests_run++;
    if (m_msg_valid !== 1'b0 || m_msg_data !== '0 || m_msg_id !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b data=%h id=%0d, need 0/0/0", m_msg_valid, m_msg_data, m_msg_id);
    end
    tests_run++;
    if (drop_count !== '0) begin
      tests_failed++;
      $display("FAIL reset_drops: got %h, need 0", drop_count);
    end
  endtask

  // Pushes on edges 1 and 2 after release are ignored.
  task automatic test_sync_release();
    rst_n = 1'b0;
    m_msg_ready = 1'b1;
    step();
    rst_n = 1'b1;
    send(0, 64'h55);
    step();
    step();
    s_msg_valid = '0;
    step();
    step();
    tests_run++;
    if (m_msg_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL sync_release: valid=%b, need 0 (early push taken)", m_msg_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    m_msg_ready = 1'b1;
    send(2, 64'hDEAD_BEEF_0000_0002);
    step();
    s_msg_valid = '0;
    tests_run++;
    if (m_msg_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_latency: valid=%b after E0, need 0", m_msg_valid);
    end
    step();
    tests_run++;
    if (m_msg_valid !== 1'b1 || m_msg_id !== 2'd2 || m_msg_data !== 64'hDEAD_BEEF_0000_0002) begin
      tests_failed++;
      $display("FAIL single_out: valid=%b id=%0d data=%h, need 1/2/deadbeef00000002", m_msg_valid, m_msg_id, m_msg_data);
    end
    step();
    tests_run++;
    if (m_msg_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle: valid=%b, need 0", m_msg_valid);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    m_msg_ready = 1'b1;
    for (int i = 0; i < NC; i++) s_msg_data[i*DW +: DW] = DW'(i);
    s_msg_valid = '1;
    step();
    s_msg_valid = '0;
    for (int i = 0; i < NC; i++) begin
      step();
      tests_run++;
      if (m_msg_valid !== 1'b1 || m_msg_id !== IW'(i) || m_msg_data !== DW'(i)) begin
        tests_failed++;
        $display("FAIL simul_out%0d: valid=%b id=%0d data=%h, need 1/%0d/%0d", i, m_msg_valid, m_msg_id, m_msg_data, i, i);
      end
    end
    step();
    tests_run++;
    if (m_msg_valid !== 1'b0 || drop_count !== '0) begin
      tests_failed++;
      $display("FAIL simul_end: valid=%b drops=%h, need 0/0", m_msg_valid, drop_count);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    m_msg_ready = 1'b0;
    s_msg_data = '0;
    s_msg_data[0*DW +: DW] = 64'h0A;
    s_msg_data[1*DW +: DW] = 64'h1A;
    s_msg_valid = 4'b0011;
    step();
    s_msg_data[0*DW +: DW] = 64'h0B;
    s_msg_data[1*DW +: DW] = 64'h1B;
    step();
    s_msg_valid = '0;
    m_msg_ready = 1'b1;
    begin
      logic [DW-1:0] exp_d [4];
      logic [IW-1:0] exp_i [4];
      exp_d = '{64'h0A, 64'h1A, 64'h0B, 64'h1B};
      exp_i = '{2'd0, 2'd1, 2'd0, 2'd1};
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (m_msg_valid !== 1'b1 || m_msg_id !== exp_i[k] || m_msg_data !== exp_d[k]) begin
          tests_failed++;
          $display("FAIL rr_out%0d: valid=%b id=%0d data=%h, need 1/%0d/%h", k, m_msg_valid, m_msg_id, m_msg_data, exp_i[k], exp_d[k]);
        end
        step();
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_msg_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      send(1, DW'(8'h10 + k));
      step();
      if (k > 0) begin
        tests_run++;
        if (m_msg_valid !== 1'b1 || m_msg_id !== 2'd1 || m_msg_data !== 64'h10) begin
          tests_failed++;
          $display("FAIL bp_hold%0d: valid=%b id=%0d data=%h, need 1/1/10", k, m_msg_valid, m_msg_id, m_msg_data);
        end
      end
    end
    s_msg_valid = '0;
    tests_run++;
    if (drop_count[1*CW +: CW] !== 16'd1 || drop_count[0*CW +: CW] !== 16'd0) begin
      tests_failed++;
      $display("FAIL bp_drop: drops=%h, need core1=1 others 0", drop_count);
    end
    m_msg_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (m_msg_valid !== 1'b1 || m_msg_data !== DW'(8'h10 + k)) begin
        tests_failed++;
        $display("FAIL bp_drain%0d: valid=%b data=%h, need 1/%h", k, m_msg_valid, m_msg_data, 8'h10 + k);
      end
      step();
    end
    tests_run++;
    if (m_msg_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_empty: valid=%b, need 0", m_msg_valid);
    end
  endtask

  task automatic test_full_same_cycle_pop();
    do_reset();
    m_msg_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(3, DW'(8'h30 + k));
      step();
    end
    // Stage holds 0x30, FIFO 3 holds 0x31..0x34 (full); pop and push together.
    m_msg_ready = 1'b1;
    send(3, 64'h35);
    step();
    s_msg_valid = '0;
    tests_run++;
    if (drop_count[3*CW +: CW] !== 16'd0) begin
      tests_failed++;
      $display("FAIL fullpop_drop: core3 drops=%0d, need 0", drop_count[3*CW +: CW]);
    end
    for (int k = 1; k < 6; k++) begin
      tests_run++;
      if (m_msg_valid !== 1'b1 || m_msg_id !== 2'd3 || m_msg_data !== DW'(8'h30 + k)) begin
        tests_failed++;
        $display("FAIL fullpop_out%0d: valid=%b id=%0d data=%h, need 1/3/%h", k, m_msg_valid, m_msg_id, m_msg_data, 8'h30 + k);
      end
      step();
    end
    tests_run++;
    if (m_msg_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fullpop_empty: valid=%b, need 0", m_msg_valid);
    end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    m_msg_ready = 1'b0;
    send(0, 64'hC0);
    // 5 accepted (stage + 4 FIFO entries), every later cycle is a drop.
    for (int n = 0; n < 5 + 100; n++) step();
    tests_run++;
    if (drop_count[0*CW +: CW] !== 16'd100) begin
      tests_failed++;
      $display("FAIL sat_partial: got %0d, need 100", drop_count[0*CW +: CW]);
    end
    for (int n = 0; n < 65535 - 100; n++) step();
    tests_run++;
    if (drop_count[0*CW +: CW] !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL sat_reach: got %h, need ffff", drop_count[0*CW +: CW]);
    end
    step();
    tests_run++;
    if (drop_count[0*CW +: CW] !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL sat_hold: got %h, need ffff", drop_count[0*CW +: CW]);
    end
    clear_drops = 1'b1;
    step();
    tests_run++;
    if (drop_count[0*CW +: CW] !== 16'd1) begin
      tests_failed++;
      $display("FAIL clear_with_drop: got %0d, need 1", drop_count[0*CW +: CW]);
    end
    s_msg_valid = '0;
    step();
    clear_drops = 1'b0;
    tests_run++;
    if (drop_count !== '0) begin
      tests_failed++;
      $display("FAIL clear_alone: got %h, need 0", drop_count);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    m_msg_ready = 1'b0;
    s_msg_data = '0;
    s_msg_data[2*DW +: DW] = 64'h22;
    for (int k = 0; k < 6; k++) begin
      s_msg_data[1*DW +: DW] = DW'(8'h10 + k);
      s_msg_valid = (k == 0) ? 4'b0110 : 4'b0010;
      step();
    end
    s_msg_valid = '0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (m_msg_valid !== 1'b0 || m_msg_data !== '0 || m_msg_id !== '0 || drop_count !== '0) begin
      tests_failed++;
      $display("FAIL midreset_async: valid=%b data=%h id=%0d drops=%h, need all 0", m_msg_valid, m_msg_data, m_msg_id, drop_count);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    m_msg_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if (m_msg_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_stale%0d: valid=%b id=%0d, need valid 0", k, m_msg_valid, m_msg_id);
      end
    end
    send(3, 64'h77);
    step();
    s_msg_valid = '0;
    step();
    tests_run++;
    if (m_msg_valid !== 1'b1 || m_msg_id !== 2'd3 || m_msg_data !== 64'h77) begin
      tests_failed++;
      $display("FAIL midreset_first: valid=%b id=%0d data=%h, need 1/3/77", m_msg_valid, m_msg_id, m_msg_data);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_sync_release();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_backpressure();
    test_full_same_cycle_pop();
    test_saturation_clear();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/core_msg_arbiter.md
# core_msg_arbiter

Collects the fire-and-forget status messages (`core_msg_data`/`core_msg_valid`) from CORE_COUNT RISC-V core wrappers and merges them onto one ready/valid message stream tagged with the source core index. Each channel has its own small FIFO so that simultaneous messages are not lost. Overflow is counted per core rather than back-pressured, because the cores' message ports have no ready signal. The block sits between the per-core wrappers and the host-facing message/status path.

## Interface
- CORE_COUNT, 4, number of input message channels (≥2)
- DATA_WIDTH, 64, message width in bits
- FIFO_DEPTH, 4, per-channel FIFO entries; power of two, ≥2
- CORE_ID_WIDTH, $clog2(CORE_COUNT), width of the source tag
- DROP_CNT_WIDTH, 16, width of each per-core drop counter

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- s_msg_data  in  CORE_COUNT*DATA_WIDTH  per-core message; core i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_msg_valid  in  CORE_COUNT  per-core one-cycle message strobe; there is no ready
- m_msg_data  out  DATA_WIDTH  merged message
- m_msg_id  out  CORE_ID_WIDTH  index of the source core
- m_msg_valid  out  1  output valid
- m_msg_ready  in  1  output ready
- drop_count  out  CORE_COUNT*DROP_CNT_WIDTH  per-core saturating count of dropped messages
- clear_drops  in  1  synchronous clear of all drop counters

## Operation
- Channel FIFO push: an entry is pushed when s_msg_valid[i]=1 and the FIFO is not full.
  - "Not full" is evaluated after the same-cycle pop: a full FIFO that is popped in the same cycle accepts the push.
- Overflow: if s_msg_valid[i]=1 and the FIFO is full with no same-cycle pop, the message is discarded and drop_count[i] increments.
  - The counter saturates at 2^DROP_CNT_WIDTH−1.
- clear_drops=1: every counter loads 0. On any channel that drops in that same cycle, the counter loads 1 instead.
- Output stage: a single register holding data, id and valid.
  - The stage loads when it is empty (m_msg_valid=0) or when it fires (m_msg_valid & m_msg_ready).
  - On a load, the arbiter pops one entry from the selected non-empty FIFO.
  - If no FIFO is non-empty, m_msg_valid goes to 0.
- Arbitration: round-robin.
  - Search starts at (last_grant+1) mod CORE_COUNT and wraps.
  - last_grant updates only on a pop.
  - After reset last_grant = CORE_COUNT−1, so channel 0 has priority first.
- Holding: while m_msg_valid=1 and m_msg_ready=0, m_msg_data and m_msg_id are held stable. No pop occurs.
- Ordering: per-channel order is preserved. Across channels there is no ordering guarantee beyond round-robin.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - m_msg_valid=0, m_msg_data=0, m_msg_id=0
  - all drop_count=0
  - all FIFOs empty, last_grant=CORE_COUNT−1
- Release of rst_n is synchronised internally with a 2-flop synchroniser. The first push is accepted at the third rising edge after rst_n rises.
- Latency:
  - A message sampled at edge E0 into an empty FIFO, with the output stage empty, appears with m_msg_valid=1 after edge E1 (one-cycle latency).
  - There is no combinational path from s_msg_* to m_msg_*.
- Throughput: one message per cycle while m_msg_ready=1 and any FIFO is non-empty.
- Reset asserted mid-transfer: all in-flight and buffered messages are lost. Outputs take their reset values immediately (asynchronously).
- drop_count updates are registered and visible one cycle after the dropping edge.

## Test plan
- Single message: core 2 sends 0xDEAD_BEEF_0000_0002 at E0 with m_msg_ready=1.
  - Required: m_msg_valid=1, m_msg_id=2, data matching, in cycle after E1; then m_msg_valid=0.
- Simultaneous: all 4 cores send value i in one cycle with ready=1.
  - Required: outputs in order id 0,1,2,3 on four consecutive cycles; drop_count all 0.
- Back-pressure and overflow: m_msg_ready=0; core 1 sends 6 messages 0x10..0x15.
  - Required: m_msg_valid=1, holding 0x10, stable throughout. The FIFO holds 0x11..0x14, so 0x15 is dropped and drop_count[1]=1.
  - After ready=1: output 0x10..0x14 in order.
- Full FIFO with same-cycle pop: core 3 FIFO full, output stage full; ready=1 and a core 3 push in the same cycle.
  - Required: push accepted, drop_count[3] unchanged, no message lost.
- Saturation and clear: force 0xFFFF drops on core 0, then one more drop.
  - Required: counter stays 0xFFFF.
  - clear_drops with a simultaneous core 0 drop → counter=1; clear alone → 0.
- Reset mid-operation: rst_n low while FIFOs hold data.
  - Required: m_msg_valid=0 immediately; no stale message appears after release.
  - The first post-reset message comes out with the correct id.
